// File: rtl/mc_controller_hs.sv
// Multicycle MIPS control FSM with a memory ready handshake, bounded wait states,
// BNE/JR/HALT support, illegal-instruction and bus-timeout traps, and a retire pulse.
module mc_controller_hs #(
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 5,
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter bit         BNE_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ZERO,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       IR_write,
  output logic       reg_dst,
  output logic       jal_reg,
  output logic       pc_to_reg,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_A,
  output logic [1:0] alu_src_B,
  output logic [1:0] pc_src,
  output logic       I_or_D,
  output logic       mem_write,
  output logic       mem_read,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic       halted,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J    = 6'd2,  OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BNE  = 6'd5,  OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10, OP_ANDI = 6'd12, OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR  = 6'd8,  FN_ADD = 6'd32, FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36, FN_OR  = 6'd37, FN_SLT = 6'd42;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011, ALU_SLT = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_RWB, S_EXEC_I, S_IWB, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_HALT, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;

  logic mem_state, timeout, r_ok;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // The handshake wins: a ready on the timeout cycle completes the access.
  assign timeout   = mem_state && !mem_ready && (wait_q == CNT_W'(MEM_TIMEOUT));
  assign r_ok      = func inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE && r_ok)                       state_d = S_EXEC_R;
        else if (opcode == OP_RTYPE && func == FN_JR)         state_d = S_JR;
        else if (opcode == OP_LW || opcode == OP_SW)          state_d = S_MEMADR;
        else if (opcode == OP_BEQ || (BNE_EN && opcode == OP_BNE)) state_d = S_BRANCH;
        else if (opcode inside {OP_ADDI, OP_SLTI, OP_ANDI})   state_d = S_EXEC_I;
        else if (opcode == OP_J)                              state_d = S_JUMP;
        else if (opcode == OP_JAL)                            state_d = S_JAL;
        else if (opcode == HALT_OPCODE)                       state_d = S_HALT;
        else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC_R: state_d = S_RWB;
      S_EXEC_I: state_d = S_IWB;
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_HALT, S_TRAP: state_d = state_q;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = 2'b10;
    end
    if (state_d != state_q || mem_ready || !mem_state) wait_d = '0;
    else                                               wait_d = wait_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    IR_write   = 1'b0;
    reg_dst    = 1'b0;
    jal_reg    = 1'b0;
    pc_to_reg  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_A  = 1'b0;
    alu_src_B  = 2'b00;
    pc_src     = 2'b00;
    I_or_D     = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    alu_op     = ALU_ADD;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_B = 2'b01;
        pc_write  = mem_ready;
        IR_write  = mem_ready;
      end
      S_DECODE: alu_src_B = 2'b11;
      S_EXEC_R: begin
        alu_src_A = 1'b1;
        case (func)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_RWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
        if (opcode == OP_SLTI)      alu_op = ALU_SLT;
        else if (opcode == OP_ANDI) alu_op = ALU_AND;
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_MEMADR: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
      end
      S_MEMRD: begin
        I_or_D   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        I_or_D    = 1'b1;
        mem_write = !timeout;
        retire    = mem_ready;
      end
      S_BRANCH: begin
        alu_src_A = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = (opcode == OP_BNE) ? !ZERO : ZERO;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      S_JAL: begin
        pc_src    = 2'b10;
        pc_write  = 1'b1;
        jal_reg   = 1'b1;
        pc_to_reg = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JR: begin
        pc_src   = 2'b11;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
    // State is already FETCH while reset is low; just mask the fetch strobes.
    if (!rst) begin
      pc_write = 1'b0;
      IR_write = 1'b0;
    end
  end

  assign halted     = (state_q == S_HALT);
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Bench for mc_controller_hs: per-cycle expected control vectors are queued as each
// stimulus cycle is driven and popped/compared at the following falling edge.
module tb_mc_controller_hs;

  logic       clk = 1'b0, rst = 1'b1, ZERO = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, func = '0;
  logic       pc_write, IR_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write, alu_src_A;
  logic [1:0] alu_src_B, pc_src;
  logic       I_or_D, mem_write, mem_read;
  logic [2:0] alu_op;
  logic       retire, halted, trap;
  logic [1:0] trap_cause;
  logic       nb_pc_write, nb_IR_write, nb_reg_dst, nb_jal_reg, nb_pc_to_reg, nb_mem_to_reg;
  logic       nb_reg_write, nb_alu_src_A, nb_I_or_D, nb_mem_write, nb_mem_read;
  logic [1:0] nb_alu_src_B, nb_pc_src;
  logic [2:0] nb_alu_op;
  logic       nb_retire, nb_halted, nb_trap;
  logic [1:0] nb_trap_cause;

  typedef struct packed {
    logic pc_write, IR_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write, alu_src_A;
    logic [1:0] alu_src_B, pc_src;
    logic I_or_D, mem_write, mem_read;
    logic [2:0] alu_op;
    logic retire, halted, trap;
    logic [1:0] trap_cause;
  } ctl_t;

  typedef struct {
    logic rdy; logic z; logic [5:0] op; logic [5:0] fn; ctl_t e;
  } step_t;

  ctl_t obs;
  ctl_t sb[$];
  int   n_run = 0, n_fail = 0;

  assign obs = {pc_write, IR_write, reg_dst, jal_reg, pc_to_reg, mem_to_reg, reg_write,
                alu_src_A, alu_src_B, pc_src, I_or_D, mem_write, mem_read, alu_op,
                retire, halted, trap, trap_cause};

  always #5 clk = ~clk;

  mc_controller_hs #(.MEM_TIMEOUT(4), .CNT_W(3), .HALT_OPCODE(6'h3F), .BNE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ZERO(ZERO), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(pc_write), .IR_write(IR_write), .reg_dst(reg_dst), .jal_reg(jal_reg),
    .pc_to_reg(pc_to_reg), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_A(alu_src_A), .alu_src_B(alu_src_B), .pc_src(pc_src), .I_or_D(I_or_D),
    .mem_write(mem_write), .mem_read(mem_read), .alu_op(alu_op), .retire(retire),
    .halted(halted), .trap(trap), .trap_cause(trap_cause)
  );

  mc_controller_hs #(.MEM_TIMEOUT(4), .CNT_W(3), .HALT_OPCODE(6'h3F), .BNE_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .ZERO(ZERO), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(nb_pc_write), .IR_write(nb_IR_write), .reg_dst(nb_reg_dst), .jal_reg(nb_jal_reg),
    .pc_to_reg(nb_pc_to_reg), .mem_to_reg(nb_mem_to_reg), .reg_write(nb_reg_write),
    .alu_src_A(nb_alu_src_A), .alu_src_B(nb_alu_src_B), .pc_src(nb_pc_src), .I_or_D(nb_I_or_D),
    .mem_write(nb_mem_write), .mem_read(nb_mem_read), .alu_op(nb_alu_op), .retire(nb_retire),
    .halted(nb_halted), .trap(nb_trap), .trap_cause(nb_trap_cause)
  );

  // Expected control vector per state.
  function automatic ctl_t m_fetch(input logic rdy);
    ctl_t m = '0; m.mem_read = 1; m.alu_src_B = 2'b01; m.pc_write = rdy; m.IR_write = rdy; return m;
  endfunction
  function automatic ctl_t m_decode();
    ctl_t m = '0; m.alu_src_B = 2'b11; return m;
  endfunction
  function automatic ctl_t m_exec_r(input logic [2:0] op);
    ctl_t m = '0; m.alu_src_A = 1; m.alu_op = op; return m;
  endfunction
  function automatic ctl_t m_rwb();
    ctl_t m = '0; m.reg_dst = 1; m.reg_write = 1; m.retire = 1; return m;
  endfunction
  function automatic ctl_t m_exec_i(input logic [2:0] op);
    ctl_t m = '0; m.alu_src_A = 1; m.alu_src_B = 2'b10; m.alu_op = op; return m;
  endfunction
  function automatic ctl_t m_iwb();
    ctl_t m = '0; m.reg_write = 1; m.retire = 1; return m;
  endfunction
  function automatic ctl_t m_memadr();
    ctl_t m = '0; m.alu_src_A = 1; m.alu_src_B = 2'b10; return m;
  endfunction
  function automatic ctl_t m_memrd();
    ctl_t m = '0; m.I_or_D = 1; m.mem_read = 1; return m;
  endfunction
  function automatic ctl_t m_memwb();
    ctl_t m = '0; m.mem_to_reg = 1; m.reg_write = 1; m.retire = 1; return m;
  endfunction
  function automatic ctl_t m_memwr(input logic rdy);
    ctl_t m = '0; m.I_or_D = 1; m.mem_write = 1; m.retire = rdy; return m;
  endfunction
  function automatic ctl_t m_branch(input logic take);
    ctl_t m = '0; m.alu_src_A = 1; m.alu_op = 3'b001; m.pc_src = 2'b01; m.pc_write = take;
    m.retire = 1; return m;
  endfunction
  function automatic ctl_t m_jump(input logic [1:0] src, input logic link);
    ctl_t m = '0; m.pc_src = src; m.pc_write = 1; m.retire = 1;
    m.jal_reg = link; m.pc_to_reg = link; m.reg_write = link; return m;
  endfunction
  function automatic ctl_t m_halt();
    ctl_t m = '0; m.halted = 1; return m;
  endfunction
  function automatic ctl_t m_trap(input logic [1:0] c);
    ctl_t m = '0; m.trap = 1; m.trap_cause = c; return m;
  endfunction

  function automatic step_t st(input logic rdy, input logic z, input logic [5:0] op,
                               input logic [5:0] fn, input ctl_t e);
    step_t r; r.rdy = rdy; r.z = z; r.op = op; r.fn = fn; r.e = e; return r;
  endfunction

  // Entered just after a rising edge; leaves inputs applied at the falling edge.
  task automatic drive(input step_t s);
    mem_ready = s.rdy; ZERO = s.z; opcode = s.op; func = s.fn;
    sb.push_back(s.e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; mem_ready = 1'b0; ZERO = 1'b0; opcode = '0; func = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    ctl_t exp;
    mem_ready = 1'b1; opcode = 6'd0; func = 6'd32;
    #1 rst = 1'b0;
    #1;
    sb.push_back(m_fetch(0));
    exp = sb.pop_front();
    n_run++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", obs, exp);
    end
    @(posedge clk); #1;
    drive(st(1, 0, 6'd0, 6'd32, m_fetch(0)));
    exp = sb.pop_front();
    n_run++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", obs, exp);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(st(1, 0, 6'd0, 6'd32, m_fetch(1)));
    exp = sb.pop_front();
    n_run++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", obs, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r_type();
    step_t s[$];
    ctl_t exp;
    logic [5:0] fns [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      s.push_back(st(1, 0, 6'd0, fns[k], m_fetch(1)));
      s.push_back(st(1, 0, 6'd0, fns[k], m_decode()));
      s.push_back(st(1, 0, 6'd0, fns[k], m_exec_r(ops[k])));
      s.push_back(st(1, 0, 6'd0, fns[k], m_rwb()));
    end
    foreach (s[i]) begin
      drive(s[i]);
      exp = sb.pop_front();
      n_run++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL r_type step %0d: got %h want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_and_imm();
    step_t s[$];
    ctl_t exp;
    logic [5:0] iop [3] = '{6'd8, 6'd10, 6'd12};
    logic [2:0] ial [3] = '{3'b000, 3'b100, 3'b010};
    do_reset();
    s.push_back(st(1, 0, 6'd35, 0, m_fetch(1)));
    s.push_back(st(1, 0, 6'd35, 0, m_decode()));
    s.push_back(st(1, 0, 6'd35, 0, m_memadr()));
    for (int k = 0; k < 3; k++) s.push_back(st(0, 0, 6'd35, 0, m_memrd()));
    s.push_back(st(1, 0, 6'd35, 0, m_memrd()));
    s.push_back(st(1, 0, 6'd35, 0, m_memwb()));
    s.push_back(st(1, 0, 6'd43, 0, m_fetch(1)));
    s.push_back(st(1, 0, 6'd43, 0, m_decode()));
    s.push_back(st(1, 0, 6'd43, 0, m_memadr()));
    s.push_back(st(1, 0, 6'd43, 0, m_memwr(1)));
    for (int k = 0; k < 3; k++) begin
      s.push_back(st(1, 0, iop[k], 0, m_fetch(1)));
      s.push_back(st(1, 0, iop[k], 0, m_decode()));
      s.push_back(st(1, 0, iop[k], 0, m_exec_i(ial[k])));
      s.push_back(st(1, 0, iop[k], 0, m_iwb()));
    end
    foreach (s[i]) begin
      drive(s[i]);
      exp = sb.pop_front();
      n_run++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL mem_imm step %0d: got %h want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    step_t s[$];
    ctl_t exp;
    logic [5:0] bop [4] = '{6'd5, 6'd4, 6'd4, 6'd5};
    logic       bz  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       btk [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      s.push_back(st(1, bz[k], bop[k], 0, m_fetch(1)));
      s.push_back(st(1, bz[k], bop[k], 0, m_decode()));
      s.push_back(st(1, bz[k], bop[k], 0, m_branch(btk[k])));
    end
    s.push_back(st(1, 0, 6'd2, 0, m_fetch(1)));
    s.push_back(st(1, 0, 6'd2, 0, m_decode()));
    s.push_back(st(1, 0, 6'd2, 0, m_jump(2'b10, 0)));
    s.push_back(st(1, 0, 6'd0, 6'd8, m_fetch(1)));
    s.push_back(st(1, 0, 6'd0, 6'd8, m_decode()));
    s.push_back(st(1, 0, 6'd0, 6'd8, m_jump(2'b11, 0)));
    foreach (s[i]) begin
      drive(s[i]);
      exp = sb.pop_front();
      n_run++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL branch step %0d: got %h want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    // The BNE_EN=0 copy saw bne first and must have trapped as illegal.
    n_run++;
    if (nb_trap !== 1'b1 || nb_trap_cause !== 2'b01 || nb_pc_write !== 1'b0 || nb_retire !== 1'b0) begin
      n_fail++;
      $display("FAIL bne_disabled: got trap=%b cause=%b pcw=%b ret=%b want trap=1 cause=01 pcw=0 ret=0",
               nb_trap, nb_trap_cause, nb_pc_write, nb_retire);
    end
  endtask

  task automatic test_illegal();
    step_t s[$];
    ctl_t exp;
    do_reset();
    s.push_back(st(1, 0, 6'd1, 0, m_fetch(1)));
    s.push_back(st(1, 0, 6'd1, 0, m_decode()));
    for (int k = 0; k < 4; k++) s.push_back(st(1, 1, 6'd0, 6'd32, m_trap(2'b01)));
    foreach (s[i]) begin
      drive(s[i]);
      exp = sb.pop_front();
      n_run++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL illegal step %0d: got %h want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t s[$];
    ctl_t exp, tmo;
    tmo = m_memwr(0);
    tmo.mem_write = 1'b0;
    for (int run = 0; run < 3; run++) begin
      s.delete();
      do_reset();
      if (run < 2) begin
        s.push_back(st(1, 0, 6'd43, 0, m_fetch(1)));
        s.push_back(st(1, 0, 6'd43, 0, m_decode()));
        s.push_back(st(1, 0, 6'd43, 0, m_memadr()));
        for (int k = 0; k < 4; k++) s.push_back(st(0, 0, 6'd43, 0, m_memwr(0)));
        if (run == 0) begin
          s.push_back(st(0, 0, 6'd43, 0, tmo));
          for (int k = 0; k < 3; k++) s.push_back(st(1'(k), 0, 6'd43, 0, m_trap(2'b10)));
        end else begin
          s.push_back(st(1, 0, 6'd43, 0, m_memwr(1)));
          s.push_back(st(1, 0, 6'd43, 0, m_fetch(1)));
          s.push_back(st(1, 0, 6'd43, 0, m_decode()));
        end
      end else begin
        for (int k = 0; k < 5; k++) s.push_back(st(0, 0, 6'd0, 0, m_fetch(0)));
        s.push_back(st(1, 0, 6'd0, 0, m_trap(2'b10)));
      end
      foreach (s[i]) begin
        drive(s[i]);
        exp = sb.pop_front();
        n_run++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL timeout run %0d step %0d: got %h want %h", run, i, obs, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jal_halt();
    step_t s[$];
    ctl_t exp;
    do_reset();
    s.push_back(st(1, 0, 6'd3, 0, m_fetch(1)));
    s.push_back(st(1, 0, 6'd3, 0, m_decode()));
    s.push_back(st(1, 0, 6'd3, 0, m_jump(2'b10, 1)));
    s.push_back(st(1, 0, 6'h3F, 0, m_fetch(1)));
    s.push_back(st(1, 0, 6'h3F, 0, m_decode()));
    for (int k = 0; k < 20; k++)
      s.push_back(st(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), m_halt()));
    foreach (s[i]) begin
      drive(s[i]);
      exp = sb.pop_front();
      n_run++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL jal_halt step %0d: got %h want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$];
    ctl_t exp;
    do_reset();
    s.push_back(st(1, 0, 6'd43, 0, m_fetch(1)));
    s.push_back(st(1, 0, 6'd43, 0, m_decode()));
    s.push_back(st(1, 0, 6'd43, 0, m_memadr()));
    s.push_back(st(0, 0, 6'd43, 0, m_memwr(0)));
    s.push_back(st(0, 0, 6'd43, 0, m_memwr(0)));
    foreach (s[i]) begin
      drive(s[i]);
      exp = sb.pop_front();
      n_run++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL reset_mid pre step %0d: got %h want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    sb.push_back(m_fetch(0));
    exp = sb.pop_front();
    n_run++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL reset_mid drop: got %h want %h", obs, exp);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    // Counter must restart at 0: four waits plus ready on the fifth cycle completes.
    s.delete();
    for (int k = 0; k < 4; k++) s.push_back(st(0, 0, 6'd43, 0, m_fetch(0)));
    s.push_back(st(1, 0, 6'd43, 0, m_fetch(1)));
    s.push_back(st(1, 0, 6'd43, 0, m_decode()));
    foreach (s[i]) begin
      drive(s[i]);
      exp = sb.pop_front();
      n_run++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL reset_mid post step %0d: got %h want %h", i, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_mem_and_imm();
    test_branch_jump();
    test_illegal();
    test_timeout();
    test_jal_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
